// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and lane helper for the audio sample engine
package audio_pkg;

    typedef enum logic [1:0] {
        MODE_LIVE  = 2'b00,
        MODE_ROM   = 2'b01,
        MODE_FLIVE = 2'b10,
        MODE_FROM  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } state_e;

    // Bit offset of a channel inside a packed multi-channel frame.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/audio_sample_engine_if.sv
// rtl/audio_sample_engine_if.sv - CODEC frame handshake bundle
interface audio_sample_engine_if #(
    parameter int DATA_W = 24,
    parameter int NCH    = 2
);
    logic                  read_ready;
    logic                  write_ready;
    logic [NCH*DATA_W-1:0] readdata;
    logic                  read;
    logic                  write;
    logic                  frame_strobe;
    logic [NCH*DATA_W-1:0] writedata;

    // CODEC side
    modport master (
        output read_ready, write_ready, readdata,
        input  read, write, frame_strobe, writedata
    );

    // Sample engine side
    modport slave (
        input  read_ready, write_ready, readdata,
        output read, write, frame_strobe, writedata
    );
endinterface

// File: rtl/moving_avg_lane.sv
// rtl/moving_avg_lane.sv - per-channel delay line and running-sum moving average
module moving_avg_lane #(
    parameter int DATA_W    = 24,
    parameter int TAPS_LOG2 = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              update,
    input  logic              flush,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] avg
);
    localparam int TAPS  = 1 << TAPS_LOG2;
    localparam int ACC_W = DATA_W + TAPS_LOG2;

    logic        [DATA_W-1:0]    line [TAPS];
    logic        [TAPS_LOG2-1:0] wr_ptr;
    logic        [DATA_W-1:0]    sample_q;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     acc_next;
    logic signed [ACC_W-1:0]     acc_base;
    logic signed [ACC_W-1:0]     newest;
    logic signed [ACC_W-1:0]     oldest;

    // Running sum: a flush makes both the sum and the dropped sample read as zero
    always_comb begin
        acc_base = flush ? '0 : acc;
        newest   = {{TAPS_LOG2{sample_q[DATA_W-1]}}, sample_q};
        oldest   = flush ? '0 : {{TAPS_LOG2{line[wr_ptr][DATA_W-1]}}, line[wr_ptr]};
        acc_next = acc_base + newest - oldest;
        avg      = DATA_W'(acc_next >>> TAPS_LOG2);
    end

    assign raw = sample_q;

    // Capture the selected sample at acceptance, then shift it into history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
            acc      <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < TAPS; i++) line[i] <= '0;
        end else begin
            if (load) sample_q <= sample;
            if (update) begin
                if (flush) begin
                    for (int i = 0; i < TAPS; i++) line[i] <= '0;
                end
                line[wr_ptr] <= sample_q;
                acc          <= acc_next;
                wr_ptr       <= wr_ptr + TAPS_LOG2'(1);
            end
        end
    end
endmodule

// File: rtl/audio_sample_engine.sv
// rtl/audio_sample_engine.sv - frame sequencer: source select, filtering and CODEC handshake
module audio_sample_engine
    import audio_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int NCH       = 2,
    parameter int ROM_DEPTH = 96000,
    parameter int ADDR_W    = $clog2(ROM_DEPTH),
    parameter int TAPS_LOG2 = 3
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic [1:0]        mode,
    audio_sample_engine_if.slave codec,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q
);
    state_e                state;
    state_e                state_next;
    mode_e                 mode_q;
    logic                  flush_q;
    logic                  settled;
    logic                  restarted;
    logic                  accept;
    logic                  restart;
    logic                  advance;
    logic                  emit;
    logic                  calc;
    logic [NCH*DATA_W-1:0] frame_next;
    logic [NCH*DATA_W-1:0] writedata_q;

    // FSM state register
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next state; a ROM source is accepted only once rom_q reflects a settled address
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        restart    = 1'b0;
        advance    = 1'b0;
        emit       = 1'b0;
        case (state)
            IDLE: begin
                restart = mode[0] && !mode_q[0] && !restarted;
                if (codec.read_ready && codec.write_ready && !restart && (!mode[0] || settled)) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: state_next = EMIT;
            EMIT: begin
                emit       = 1'b1;
                advance    = mode_q[0];
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign calc               = (state == CALC);
    assign codec.read         = emit;
    assign codec.write        = emit;
    assign codec.frame_strobe = emit;
    assign codec.writedata    = writedata_q;

    // Mode latch, source-change flush flag and ROM address sequencing
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            mode_q    <= MODE_LIVE;
            flush_q   <= 1'b0;
            restarted <= 1'b0;
            settled   <= 1'b1;
            rom_addr  <= '0;
        end else begin
            settled <= !(restart || advance);
            if (accept) begin
                mode_q    <= mode_e'(mode);
                flush_q   <= mode[0] ^ mode_q[0];
                restarted <= 1'b0;
            end else if (restart) begin
                restarted <= 1'b1;
            end
            if (restart)
                rom_addr <= '0;
            else if (advance)
                rom_addr <= (rom_addr == ADDR_W'(ROM_DEPTH - 1)) ? '0 : rom_addr + ADDR_W'(1);
        end
    end

    // Output frame is registered at the end of CALC and held until the next CALC
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)  writedata_q <= '0;
        else if (calc) writedata_q <= frame_next;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        logic [DATA_W-1:0] src;
        logic [DATA_W-1:0] raw;
        logic [DATA_W-1:0] avg;

        assign src = mode[0] ? rom_q : codec.readdata[lane_lsb(k, DATA_W) +: DATA_W];

        moving_avg_lane #(
            .DATA_W   (DATA_W),
            .TAPS_LOG2(TAPS_LOG2)
        ) u_lane (
            .clk   (CLOCK_50),
            .rst_n (reset_n),
            .load  (accept),
            .update(calc),
            .flush (flush_q),
            .sample(src),
            .raw   (raw),
            .avg   (avg)
        );

        assign frame_next[lane_lsb(k, DATA_W) +: DATA_W] = mode_q[1] ? avg : raw;
    end
endmodule
